// File: rtl/baud_pkg.sv
// Shared constants for the RS-485 baud generator: reference clock and 16x divisor presets.
// A preset is div + frac/256 clk25 cycles per oversample tick.
package baud_pkg;

  localparam int CLK25_HZ       = 25_000_000;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    RATE_9600,
    RATE_19200,
    RATE_57600,
    RATE_115200
  } baud_rate_e;

  typedef struct packed {
    logic [15:0] div;
    logic [7:0]  frac;
  } baud_preset_t;

  localparam baud_preset_t BAUD_9600   = '{div: 16'd162, frac: 8'd195};
  localparam baud_preset_t BAUD_19200  = '{div: 16'd81,  frac: 8'd97};
  localparam baud_preset_t BAUD_57600  = '{div: 16'd27,  frac: 8'd33};
  localparam baud_preset_t BAUD_115200 = '{div: 16'd13,  frac: 8'd144};

  function automatic baud_preset_t baud_preset(input baud_rate_e rate);
    baud_preset_t p;
    case (rate)
      RATE_19200:  p = BAUD_19200;
      RATE_57600:  p = BAUD_57600;
      RATE_115200: p = BAUD_115200;
      default:     p = BAUD_9600;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/baud_gen_if.sv
// Control/status bundle between the baud generator and its UART clients.
interface baud_gen_if
  import baud_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 8
);
  logic              en;
  logic              resync;
  logic [DIV_W-1:0]  div_i;
  logic [FRAC_W-1:0] frac_i;
  logic              div_wr;
  logic              div_busy;
  logic              tick_os;
  logic              tick_bit;
  logic              bit_clk;

  modport master (
    output en, resync, div_i, frac_i, div_wr,
    input  div_busy, tick_os, tick_bit, bit_clk
  );

  modport slave (
    input  en, resync, div_i, frac_i, div_wr,
    output div_busy, tick_os, tick_bit, bit_clk
  );
endinterface

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds frac on every oversample wrap; carry lengthens the next period.
// Only built when BAUD_GEN_FRAC_EN is defined.
`ifdef BAUD_GEN_FRAC_EN
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int FRAC_W = 8
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry,
  output logic              carry_nxt
);
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] acc_nxt;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, frac};

  always_comb begin
    acc_nxt   = acc;
    carry_nxt = carry;
    if (clr) begin
      acc_nxt   = '0;
      carry_nxt = 1'b0;
    end else if (step) begin
      acc_nxt   = sum[FRAC_W-1:0];
      carry_nxt = sum[FRAC_W];
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      carry <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      carry <= carry_nxt;
    end
  end
endmodule
`endif

// File: rtl/baud_gen.sv
// Baud generator: oversample/bit clock-enables and a bit-rate square wave from clk25, runtime divisor.
// Fractional divisor present only when BAUD_GEN_FRAC_EN is defined.
module baud_gen
  import baud_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DEF_DIV    = 162,
  parameter int DEF_FRAC   = 195
) (
  input logic       clk25,
  input logic       rst,
  baud_gen_if.slave bus
);
  localparam int BC_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [BC_W-1:0] BIT_LAST      = BC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BIT_MID       = BC_W'(OVERSAMPLE / 2);
  localparam logic [BC_W-1:0] BIT_HALF_LAST = BC_W'(OVERSAMPLE / 2 - 1);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  logic [DIV_W-1:0] os_cnt, os_cnt_d;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_d;
  logic             bit_clk, bit_clk_d;
  logic             tick_os, tick_os_d;
  logic             tick_bit, tick_bit_d;
  logic [DIV_W-1:0] div_act, div_act_d;
  logic [DIV_W-1:0] div_pend, div_pend_d;
  logic             busy, busy_d;
  logic             carry, carry_nxt;
  logic [DIV_W:0]   len_d;

  // tick_os is exactly the wrap condition of the current cycle, so it doubles as the wrap strobe.
  logic wr_direct, wr_pend, apply_pend;
  assign wr_direct  = bus.div_wr & bus.en & bus.resync;
  assign wr_pend    = bus.div_wr & ~wr_direct;
  assign apply_pend = busy & ~bus.div_wr & (~bus.en | bus.resync | tick_os);

  always_comb begin
    div_act_d  = div_act;
    div_pend_d = div_pend;
    busy_d     = busy;
    if (wr_direct) begin
      div_act_d = clamp_div(bus.div_i);
      busy_d    = 1'b0;
    end else if (wr_pend) begin
      div_pend_d = clamp_div(bus.div_i);
      busy_d     = 1'b1;
    end else if (apply_pend) begin
      div_act_d = div_pend;
      busy_d    = 1'b0;
    end
  end

  always_comb begin
    os_cnt_d  = os_cnt;
    bit_cnt_d = bit_cnt;
    bit_clk_d = bit_clk;
    if (!bus.en) begin
      os_cnt_d  = '0;
      bit_cnt_d = '0;
      bit_clk_d = 1'b0;
    end else if (bus.resync) begin
      os_cnt_d  = '0;
      bit_cnt_d = BIT_MID;
      bit_clk_d = 1'b1;
    end else if (tick_os) begin
      os_cnt_d  = '0;
      bit_cnt_d = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      if (bit_cnt == BIT_HALF_LAST || bit_cnt == BIT_LAST)
        bit_clk_d = ~bit_clk;
    end else begin
      os_cnt_d = os_cnt + 1'b1;
    end
  end

  // Ticks are registered by looking ahead at next-cycle counter and period length.
  assign len_d      = {1'b0, div_act_d} + {{DIV_W{1'b0}}, carry_nxt};
  assign tick_os_d  = bus.en & ({1'b0, os_cnt_d} == (len_d - 1'b1));
  assign tick_bit_d = tick_os_d & (bit_cnt_d == BIT_LAST);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      os_cnt   <= '0;
      bit_cnt  <= '0;
      bit_clk  <= 1'b0;
      tick_os  <= 1'b0;
      tick_bit <= 1'b0;
      div_act  <= DIV_W'(DEF_DIV);
      div_pend <= DIV_W'(DEF_DIV);
      busy     <= 1'b0;
    end else begin
      os_cnt   <= os_cnt_d;
      bit_cnt  <= bit_cnt_d;
      bit_clk  <= bit_clk_d;
      tick_os  <= tick_os_d;
      tick_bit <= tick_bit_d;
      div_act  <= div_act_d;
      div_pend <= div_pend_d;
      busy     <= busy_d;
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] frac_act, frac_act_d;
  logic [FRAC_W-1:0] frac_pend, frac_pend_d;
  logic              acc_clr;

  assign acc_clr = ~bus.en | bus.resync;

  baud_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
    .clk25     (clk25),
    .rst       (rst),
    .clr       (acc_clr),
    .step      (tick_os),
    .frac      (frac_act),
    .carry     (carry),
    .carry_nxt (carry_nxt)
  );

  always_comb begin
    frac_act_d  = frac_act;
    frac_pend_d = frac_pend;
    if (wr_direct)
      frac_act_d = bus.frac_i;
    else if (wr_pend)
      frac_pend_d = bus.frac_i;
    else if (apply_pend)
      frac_act_d = frac_pend;
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      frac_act  <= FRAC_W'(DEF_FRAC);
      frac_pend <= FRAC_W'(DEF_FRAC);
    end else begin
      frac_act  <= frac_act_d;
      frac_pend <= frac_pend_d;
    end
  end
`else
  assign carry     = 1'b0;
  assign carry_nxt = 1'b0;
  logic unused_frac;
  assign unused_frac = ^{bus.frac_i, DEF_FRAC[FRAC_W-1:0]};
`endif

  assign bus.div_busy = busy;
  assign bus.tick_os  = tick_os;
  assign bus.tick_bit = tick_bit;
  assign bus.bit_clk  = bit_clk;

endmodule

// File: tb/tb_baud_gen.sv
// Testbench for baud_gen: arithmetic tick-schedule model, divisor-load vector table, en/resync sequences.
module tb_baud_gen;
  localparam int OS = 16;
  localparam int FW = 8;
`ifdef BAUD_GEN_FRAC_EN
  localparam int TB_DEF_DIV  = 162;
  localparam int TB_DEF_FRAC = 195;
  localparam bit FRAC_ON     = 1'b1;
`else
  localparam int TB_DEF_DIV  = 163;
  localparam int TB_DEF_FRAC = 0;
  localparam bit FRAC_ON     = 1'b0;
`endif

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  always #20 clk25 = ~clk25;

  baud_gen_if #(.DIV_W(16), .FRAC_W(FW)) bus ();

  baud_gen #(
    .DIV_W(16), .FRAC_W(FW), .OVERSAMPLE(OS), .DEF_DIV(TB_DEF_DIV), .DEF_FRAC(195)
  ) dut (
    .clk25 (clk25),
    .rst   (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cur_div, cur_frac;

  typedef struct {
    int div_i;
    int exp_len;
  } load_vec_t;

  task automatic chk(input string name, input longint act, input longint exp, output bit good);
    n_cmp++;
    good = (act == exp);
    if (!good) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Extra cycles added after the k-th wrap: how often floor(j*frac/2^FW) stepped between j=k-1 and k.
  function automatic int carry_of(input int k, input int frac);
    return ((k * frac) >> FW) - (((k - 1) * frac) >> FW);
  endfunction

  // Called just after a rising edge; that cycle is t=1 of a freshly phased generator.
  // n0 = oversample ticks already elapsed in the bit (0 after reset/en, OS/2 after resync).
  task automatic run_check(input string tag, input int div, input int frac, input int n0, input int ncyc);
    int eff;
    int next_tick;
    int k;
    bit good, g;
    bit e_tick, e_bit, e_clk;
    eff = (div < 2) ? 2 : div;
    next_tick = eff;
    k = 0;
    good = 1'b1;
    for (int t = 1; t <= ncyc && good; t++) begin
      @(negedge clk25);
      e_tick = (t == next_tick);
      e_clk  = (((n0 + k) % OS) >= OS / 2);
      e_bit  = e_tick && (((n0 + k) % OS) == OS - 1);
      chk($sformatf("%s tick_os t=%0d", tag, t), bus.tick_os, e_tick, g);   good &= g;
      chk($sformatf("%s tick_bit t=%0d", tag, t), bus.tick_bit, e_bit, g);  good &= g;
      chk($sformatf("%s bit_clk t=%0d", tag, t), bus.bit_clk, e_clk, g);    good &= g;
      chk($sformatf("%s div_busy t=%0d", tag, t), bus.div_busy, 0, g);      good &= g;
      if (e_tick) begin
        k++;
        next_tick += eff + carry_of(k, frac);
      end
    end
  endtask

  task automatic wait_tick(input string tag, output int n);
    n = 0;
    for (int i = 1; i <= 4000 && n == 0; i++) begin
      @(negedge clk25);
      if (bus.tick_os) n = i;
    end
    if (n == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no tick_os, want one within 4000 cycles", tag);
    end
  endtask

  initial begin
    load_vec_t lv[7];
    int prev, n, w, eff;
    bit g;

    lv[0] = '{13, 13};
    lv[1] = '{0, 2};
    lv[2] = '{1, 2};
    lv[3] = '{2, 2};
    lv[4] = '{7, 7};
    lv[5] = '{40, 40};
    lv[6] = '{163, 163};

    bus.en = 1'b1; bus.resync = 1'b0; bus.div_wr = 1'b0; bus.div_i = '0; bus.frac_i = '0;

    repeat (3) @(posedge clk25);
    @(negedge clk25);
    chk("reset tick_os", bus.tick_os, 0, g);
    chk("reset tick_bit", bus.tick_bit, 0, g);
    chk("reset bit_clk", bus.bit_clk, 0, g);
    chk("reset div_busy", bus.div_busy, 0, g);

    @(posedge clk25); #1;
    rst = 1'b0;
    cur_div = TB_DEF_DIV;
    cur_frac = TB_DEF_FRAC;
    run_check("after_reset", cur_div, cur_frac, 0, 2 * OS * TB_DEF_DIV + 20);

    // Random phase resyncs; even trials also load a random divisor in the resync cycle.
    for (int i = 0; i < 10; i++) begin
      w = $urandom_range(0, 60);
      repeat (w + 1) @(posedge clk25);
      #1;
      bus.resync = 1'b1;
      if (i % 2 == 0) begin
        cur_div = $urandom_range(0, 40);
        bus.div_i = 16'(cur_div);
        bus.frac_i = 8'($urandom_range(0, 255));
        cur_frac = FRAC_ON ? int'(bus.frac_i) : 0;
        bus.div_wr = 1'b1;
      end
      @(posedge clk25); #1;
      bus.resync = 1'b0;
      bus.div_wr = 1'b0;
      eff = (cur_div < 2) ? 2 : cur_div;
      run_check($sformatf("rand%0d div=%0d", i, cur_div), cur_div, cur_frac, OS / 2, 26 * (eff + 1));
    end

    // Divisor-load table: each load lands mid-period and must wait for the wrap.
    @(posedge clk25); #1;
    bus.resync = 1'b1; bus.div_wr = 1'b1; bus.div_i = 16'd162; bus.frac_i = 8'd0;
    @(posedge clk25); #1;
    bus.resync = 1'b0; bus.div_wr = 1'b0;
    wait_tick("table_base", n);
    chk("table_base len", n, 162, g);
    prev = 162;
    for (int i = 0; i < 7; i++) begin
      w = (prev >= 8) ? 5 : 0;
      repeat (w + 1) @(posedge clk25);
      #1;
      bus.div_wr = 1'b1; bus.div_i = 16'(lv[i].div_i); bus.frac_i = 8'd0;
      @(posedge clk25); #1;
      bus.div_wr = 1'b0;
      chk($sformatf("load%0d busy_rise", i), bus.div_busy, 1, g);
      wait_tick($sformatf("load%0d old", i), n);
      chk($sformatf("load%0d old_len", i), n, prev - 1 - w, g);
      chk($sformatf("load%0d busy_at_wrap", i), bus.div_busy, 1, g);
      @(posedge clk25); #1;
      chk($sformatf("load%0d busy_fall", i), bus.div_busy, 0, g);
      wait_tick($sformatf("load%0d new", i), n);
      chk($sformatf("load%0d new_len", i), n, lv[i].exp_len, g);
      prev = lv[i].exp_len;
    end

    // Second write while busy replaces the pending value.
    repeat (6) @(posedge clk25);
    #1;
    bus.div_wr = 1'b1; bus.div_i = 16'd50;
    @(posedge clk25); #1;
    bus.div_i = 16'd9;
    @(posedge clk25); #1;
    bus.div_wr = 1'b0;
    wait_tick("overwrite old", n);
    wait_tick("overwrite new", n);
    chk("overwrite new_len", n, 9, g);

    // en drop mid-period, load while idle, then restart with a full first period.
    @(posedge clk25); #1;
    bus.resync = 1'b1;
    @(posedge clk25); #1;
    bus.resync = 1'b0;
    repeat (3) @(posedge clk25);
    #1;
    chk("pre_drop bit_clk", bus.bit_clk, 1, g);
    bus.en = 1'b0;
    @(posedge clk25); #1;
    chk("en_low tick_os", bus.tick_os, 0, g);
    chk("en_low tick_bit", bus.tick_bit, 0, g);
    chk("en_low bit_clk", bus.bit_clk, 0, g);
    chk("en_low div_busy", bus.div_busy, 0, g);
    bus.div_wr = 1'b1; bus.div_i = 16'd5; bus.frac_i = 8'd0;
    @(posedge clk25); #1;
    bus.div_wr = 1'b0;
    chk("idle_load busy_rise", bus.div_busy, 1, g);
    @(posedge clk25); #1;
    chk("idle_load busy_fall", bus.div_busy, 0, g);
    chk("idle_load tick_os", bus.tick_os, 0, g);
    bus.en = 1'b1;
    run_check("en_restart", 5, 0, 0, 26 * 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
